led_frame_buffer: RTL and testbench
===================================

LED_FRAME_BUFFER -- requirements
Module: led_frame_buffer

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 20, number of LEDs per frame; AddrWidth = $clog2(NUM_LEDS).
REQ-002 SHALL have parameter COLOR_WIDTH, default 8, bits per colour channel.
REQ-003 SHALL have ports, in order: clk_in, input, 1, sole clock, all logic on posedge; rst_n_in, input, 1, synchronous active-low reset.
REQ-004 SHALL have ports: wr_en, input, 1, write strobe; wr_addr, input, AddrWidth, LED index; wr_red / wr_green / wr_blue, input, COLOR_WIDTH each, write data.
REQ-005 SHALL have ports: swap_req, input, 1, request to exchange front/back banks; swap_done, output, 1, one-cycle pulse when the swap executes; swap_pending, output, 1, swap requested but not yet executed.
REQ-006 SHALL have ports: req_addr, input, AddrWidth, LED index requested by the downstream driver; req_valid, input, 1, single-cycle request pulse.
REQ-007 SHALL have ports: red_out / green_out / blue_out, output, COLOR_WIDTH each; color_valid, output, 1, single-cycle pulse qualifying the colour outputs; req_drop, output, 1, sticky request-overrun flag.

Function
REQ-008 SHALL hold two banks of NUM_LEDS x 3*COLOR_WIDTH storage; bank_sel selects the front (read) bank; the other bank is the back (write) bank.
REQ-009 SHALL write wr_* data into the back bank at wr_addr on any cycle with wr_en=1; wr_addr >= NUM_LEDS SHALL be ignored with no storage change.
REQ-010 Read pipeline FSM states: IDLE, READ, (SCALE when BRIGHTNESS_EN is defined), OUT; OUT returns to IDLE after one cycle.
REQ-011 IDLE -> READ on req_valid=1; the front bank is read at req_addr; OUT drives color_valid=1 with the colour for one cycle.
REQ-012 Latency from the req_valid cycle to the color_valid cycle SHALL be 2 cycles without BRIGHTNESS_EN and 3 cycles with it.
REQ-013 req_addr >= NUM_LEDS SHALL still produce a color_valid pulse, with all channels 0.
REQ-014 req_valid while the FSM is not IDLE SHALL be dropped, set req_drop=1 until reset, and leave the in-flight read unaffected.
REQ-015 swap_req=1 SHALL set swap_pending; repeated swap_req while pending SHALL have no additional effect.
REQ-016 Swap executes on an accepted request with req_addr==0 while swap_pending=1: bank_sel toggles before that read, so the read uses the new front bank; swap_pending clears; swap_done pulses in the same cycle.
REQ-017 Swaps SHALL never occur mid-frame; a pending swap waits indefinitely for the next address-0 request.
REQ-018 A write in the swap cycle SHALL target the pre-swap back bank, which becomes the front bank.
REQ-019 swap_req and a swap-executing request in the same cycle: the current swap executes and swap_pending SHALL remain 1 for a second swap.
REQ-020 Outputs red_out, green_out and blue_out SHALL hold their last value outside color_valid cycles.

Reset
REQ-021 When rst_n_in=0 at a clock edge: FSM=IDLE, bank_sel=0, swap_pending=0, swap_done=0, color_valid=0, req_drop=0, and all colour outputs 0.
REQ-022 Storage contents SHALL NOT be cleared by reset.
REQ-023 Reset asserted mid-read SHALL abort the read with no color_valid pulse.

Configuration
REQ-024 Macro LED_FRAME_BUFFER_BRIGHTNESS_EN, when defined, SHALL add input brightness_in (COLOR_WIDTH) and a SCALE stage computing each channel as (channel * brightness_in) >> COLOR_WIDTH. brightness_in is sampled in SCALE, and a full-width product is computed before truncation.
REQ-025 When the macro is undefined, there SHALL be no brightness_in port and no SCALE stage, and channels pass unmodified.

Verification
REQ-026 Write back bank addr 3 = (R10,G20,B30); swap_req; req addr 0, then req addr 3 -> swap_done pulses with the addr-0 request; addr 3 returns (10,20,30) at latency 2.
REQ-027 With no swap, req addr 3 after the REQ-026 write -> returns the old front-bank data, not (10,20,30).
REQ-028 req addr 25 (NUM_LEDS=20) -> color_valid with (0,0,0); wr_addr 25 -> no bank change.
REQ-029 Two req_valid pulses one cycle apart -> one color_valid pulse only; req_drop=1 until rst_n_in=0.
REQ-030 BRIGHTNESS_EN build, stored (255,128,0), brightness_in=128 -> (127,64,0) at latency 3.
REQ-031 Reset pulse during READ -> no color_valid pulse; bank_sel=0; swap_pending=0.

Source files
------------

// File: rtl/led_frame_buffer.sv
// Double-buffered LED colour store with a request/response read pipeline.
// Define LED_FRAME_BUFFER_BRIGHTNESS_EN to add brightness_in and a SCALE stage.
module led_frame_buffer #(
  parameter  int NUM_LEDS    = 20,
  parameter  int COLOR_WIDTH = 8,
  localparam int AddrWidth   = $clog2(NUM_LEDS)
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   wr_en,
  input  logic [AddrWidth-1:0]   wr_addr,
  input  logic [COLOR_WIDTH-1:0] wr_red,
  input  logic [COLOR_WIDTH-1:0] wr_green,
  input  logic [COLOR_WIDTH-1:0] wr_blue,
  input  logic                   swap_req,
  output logic                   swap_done,
  output logic                   swap_pending,
  input  logic [AddrWidth-1:0]   req_addr,
  input  logic                   req_valid,
  output logic [COLOR_WIDTH-1:0] red_out,
  output logic [COLOR_WIDTH-1:0] green_out,
  output logic [COLOR_WIDTH-1:0] blue_out,
  output logic                   color_valid,
`ifdef LED_FRAME_BUFFER_BRIGHTNESS_EN
  input  logic [COLOR_WIDTH-1:0] brightness_in,
`endif
  output logic                   req_drop
);

  // state | meaning
  // IDLE  | waiting for req_valid; address-0 request may execute a pending swap
  // READ  | front bank read at the latched address
  // SCALE | channels multiplied by brightness_in (brightness build only)
  // OUT   | color_valid asserted for one cycle

  localparam int PixW = 3 * COLOR_WIDTH;
  localparam logic [AddrWidth:0] NumLedsW = (AddrWidth + 1)'(NUM_LEDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
`ifdef LED_FRAME_BUFFER_BRIGHTNESS_EN
    SCALE = 2'd2,
`endif
    OUT   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [PixW-1:0]        bank_q [2][NUM_LEDS];
  logic                   bank_sel_q, bank_sel_d;
  logic                   pending_q, pending_d;
  logic                   swap_done_q, swap_done_d;
  logic                   drop_q, drop_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic                   in_range_q, in_range_d;
  logic [COLOR_WIDTH-1:0] red_q, red_d;
  logic [COLOR_WIDTH-1:0] green_q, green_d;
  logic [COLOR_WIDTH-1:0] blue_q, blue_d;
  logic                   wr_in_range;
  logic                   accept;
  logic                   swap_exec;
  logic [PixW-1:0]        rd_pix;

`ifdef LED_FRAME_BUFFER_BRIGHTNESS_EN
  logic [PixW-1:0]        pix_q, pix_d;

  function automatic logic [COLOR_WIDTH-1:0] scale_chan(
    input logic [COLOR_WIDTH-1:0] chan,
    input logic [COLOR_WIDTH-1:0] gain
  );
    logic [2*COLOR_WIDTH-1:0] prod;
    prod = {{COLOR_WIDTH{1'b0}}, chan} * {{COLOR_WIDTH{1'b0}}, gain};
    return prod[2*COLOR_WIDTH-1:COLOR_WIDTH];
  endfunction
`endif

  assign wr_in_range = {1'b0, wr_addr} < NumLedsW;

  // Storage is deliberately never reset; writes always land in the back bank.
  always_ff @(posedge clk_in) begin
    if (wr_en && wr_in_range) begin
      bank_q[~bank_sel_q][wr_addr] <= {wr_red, wr_green, wr_blue};
    end
  end

  assign rd_pix = in_range_q ? bank_q[bank_sel_q][addr_q] : '0;

  always_comb begin
    state_d     = state_q;
    bank_sel_d  = bank_sel_q;
    pending_d   = pending_q;
    swap_done_d = 1'b0;
    drop_d      = drop_q;
    addr_d      = addr_q;
    in_range_d  = in_range_q;
    red_d       = red_q;
    green_d     = green_q;
    blue_d      = blue_q;
`ifdef LED_FRAME_BUFFER_BRIGHTNESS_EN
    pix_d       = pix_q;
`endif
    accept      = (state_q == IDLE) && req_valid;
    swap_exec   = accept && (req_addr == '0) && pending_q;

    if (req_valid && (state_q != IDLE)) begin
      drop_d = 1'b1;
    end

    // The toggle lands before READ, so the address-0 read sees the new front bank.
    if (swap_exec) begin
      bank_sel_d  = ~bank_sel_q;
      swap_done_d = 1'b1;
    end
    if (swap_req) begin
      pending_d = 1'b1;
    end else if (swap_exec) begin
      pending_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d     = req_addr;
          in_range_d = {1'b0, req_addr} < NumLedsW;
          state_d    = READ;
        end
      end
      READ: begin
`ifdef LED_FRAME_BUFFER_BRIGHTNESS_EN
        pix_d   = rd_pix;
        state_d = SCALE;
`else
        {red_d, green_d, blue_d} = rd_pix;
        state_d = OUT;
`endif
      end
`ifdef LED_FRAME_BUFFER_BRIGHTNESS_EN
      SCALE: begin
        red_d   = scale_chan(pix_q[PixW-1 -: COLOR_WIDTH], brightness_in);
        green_d = scale_chan(pix_q[2*COLOR_WIDTH-1 -: COLOR_WIDTH], brightness_in);
        blue_d  = scale_chan(pix_q[COLOR_WIDTH-1:0], brightness_in);
        state_d = OUT;
      end
`endif
      OUT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      bank_sel_q  <= 1'b0;
      pending_q   <= 1'b0;
      swap_done_q <= 1'b0;
      drop_q      <= 1'b0;
      addr_q      <= '0;
      in_range_q  <= 1'b0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
`ifdef LED_FRAME_BUFFER_BRIGHTNESS_EN
      pix_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bank_sel_q  <= bank_sel_d;
      pending_q   <= pending_d;
      swap_done_q <= swap_done_d;
      drop_q      <= drop_d;
      addr_q      <= addr_d;
      in_range_q  <= in_range_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
`ifdef LED_FRAME_BUFFER_BRIGHTNESS_EN
      pix_q       <= pix_d;
`endif
    end
  end

  assign swap_done    = swap_done_q;
  assign swap_pending = pending_q;
  assign req_drop     = drop_q;
  assign color_valid  = (state_q == OUT);
  assign red_out      = red_q;
  assign green_out    = green_q;
  assign blue_out     = blue_q;

endmodule

// File: tb/tb_led_frame_buffer.sv
// Randomized scoreboard bench for led_frame_buffer (default build, no brightness stage).
module tb_led_frame_buffer;
  localparam int N  = 20;
  localparam int CW = 8;
  localparam int AW = 5;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] wr_red, wr_green, wr_blue;
  logic          swap_req;
  logic          swap_done, swap_pending;
  logic [AW-1:0] req_addr;
  logic          req_valid;
  logic [CW-1:0] red_out, green_out, blue_out;
  logic          color_valid, req_drop;

  led_frame_buffer #(.NUM_LEDS(N), .COLOR_WIDTH(CW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_red(wr_red), .wr_green(wr_green), .wr_blue(wr_blue),
    .swap_req(swap_req), .swap_done(swap_done), .swap_pending(swap_pending),
    .req_addr(req_addr), .req_valid(req_valid),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .color_valid(color_valid), .req_drop(req_drop)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] pix;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [23:0] mbank [2][N];
  bit          fs, m_pend, m_drop;
  int          next_free = 0;
  int          sd_cyc = -1;
  bit          exp_pend_q, exp_drop_q, rst_smp;
  logic [23:0] last_pix = '0;
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;

  // Model state becomes visible on the DUT pins one edge after it is driven.
  always @(posedge clk_in) begin
    exp_pend_q <= m_pend;
    exp_drop_q <= m_drop;
    rst_smp    <= rst_n_in;
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk_in) begin
    if (cyc >= 2) begin
      if (!rst_smp) begin
        check("reset_color_valid", color_valid, 0);
        check("reset_rgb", {red_out, green_out, blue_out}, 0);
        last_pix = '0;
      end else if (color_valid) begin
        if (sb.size() == 0) begin
          check("spurious_color_valid", color_valid, 0);
        end else begin
          mon_e = sb.pop_front();
          check("pixel", {red_out, green_out, blue_out}, mon_e.pix);
          check("latency_cycle", cyc, mon_e.due);
          last_pix = mon_e.pix;
        end
      end else begin
        check("hold_rgb", {red_out, green_out, blue_out}, last_pix);
      end
      if (sb.size() > 0 && sb[0].due < cyc) begin
        mon_e = sb.pop_front();
        check("missing_color_valid_due", cyc, mon_e.due);
      end
      check("swap_done", swap_done, (cyc == sd_cyc));
      check("swap_pending", swap_pending, exp_pend_q);
      check("req_drop", req_drop, exp_drop_q);
    end
  end

  // One cycle of stimulus plus the reference-model update for it.
  task automatic drive(input bit we, input logic [AW-1:0] wa, input logic [CW-1:0] r,
                       input logic [CW-1:0] g, input logic [CW-1:0] b, input bit sr,
                       input bit rv, input logic [AW-1:0] ra);
    bit   accept, exec;
    exp_t e;
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    wr_en = we; wr_addr = wa; wr_red = r; wr_green = g; wr_blue = b;
    swap_req = sr; req_valid = rv; req_addr = ra;
    accept = rv && (cyc >= next_free);
    if (rv && !accept) m_drop = 1'b1;
    if (we && wa < N) mbank[!fs][wa] = {r, g, b};
    exec = accept && (ra == 0) && m_pend;
    if (exec) begin
      fs = !fs;
      sd_cyc = cyc + 1;
    end
    if (sr) m_pend = 1'b1;
    else if (exec) m_pend = 1'b0;
    if (accept) begin
      next_free = cyc + 3;
      e.pix = (ra < N) ? mbank[fs][ra] : 24'h0;
      e.due = cyc + 2;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_pulse();
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b0;
    wr_en = 0; swap_req = 0; req_valid = 0;
    while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
    if (sd_cyc > cyc) sd_cyc = -1;
    fs = 0; m_pend = 0; m_drop = 0;
    next_free = cyc + 1;
  endtask

  task automatic fill_back();
    for (int a = 0; a < N; a++)
      drive(1, AW'(a), CW'($urandom), CW'($urandom), CW'($urandom), 0, 0, 0);
  endtask

  initial begin
    rst_n_in = 1'b0;
    wr_en = 0; wr_addr = 0; wr_red = 0; wr_green = 0; wr_blue = 0;
    swap_req = 0; req_valid = 0; req_addr = 0;
    repeat (3) @(posedge clk_in);

    // Populate both banks so every later read has a known expectation.
    fill_back();
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);
    fill_back();
    idle(2);

    // Back-bank write, swap on address 0, then read the new front bank.
    drive(1, 3, 10, 20, 30, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    idle(1);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    drive(0, 0, 0, 0, 0, 0, 1, 3);
    idle(3);

    // No swap: address 3 still reads the front bank, not the new write.
    drive(1, 3, 11, 22, 33, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 3);
    idle(3);

    // Out-of-range read and write.
    drive(1, 25, 8'hAA, 8'hBB, 8'hCC, 0, 1, 25);
    idle(3);

    // Swap request coinciding with the executing request keeps a second swap pending.
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 1, 2, 3, 1, 1, 0);
    idle(2);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);

    // Back-to-back requests: the second is dropped and req_drop sticks.
    drive(0, 0, 0, 0, 0, 0, 1, 7);
    drive(0, 0, 0, 0, 0, 0, 1, 8);
    idle(4);

    // Swap pending with bank_sel=1, then reset while a read is in flight.
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 5);
    reset_pulse();
    idle(2);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1) == 1, AW'($urandom_range(0, 31)),
            CW'($urandom), CW'($urandom), CW'($urandom),
            $urandom_range(0, 6) == 0, $urandom_range(0, 2) == 0,
            ($urandom_range(0, 3) == 0) ? AW'(0) : AW'($urandom_range(0, 24)));
    end
    idle(5);
    check("scoreboard_drained", sb.size(), 0);

    reset_pulse();
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish by cycle %0d", cyc);
    $fatal(1);
  end
endmodule
